// File: rtl/pipe_wb_regfile.sv
// Write-back stage and architectural register file: selects the write-back
// data, commits it, and serves two bypassed read ports plus a debug port.
module pipe_wb_regfile #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [WIDTH-1:0]  wmo,
  input  logic [WIDTH-1:0]  walu,
  input  logic [ADDR_W-1:0] wrn,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  output logic [WIDTH-1:0]  qa,
  output logic [WIDTH-1:0]  qb,
  output logic [WIDTH-1:0]  wdi,
  output logic              wcommit,
  input  logic [ADDR_W-1:0] dbg_rn,
  output logic [WIDTH-1:0]  dbg_q,
  output logic [31:0]       wb_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [WIDTH-1:0] r_regs [0:NREG-1];
  logic [31:0]      r_wb_count;
  logic [WIDTH-1:0] w_wdi;
  logic             w_commit;

  assign w_wdi    = wm2reg ? wmo : walu;
  assign w_commit = wwreg & (wrn != '0);

  // Entry 0 is cleared by reset and never written; reads mask it regardless.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[wrn] <= w_wdi;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wb_count <= '0;
    end else if (w_commit) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  function automatic logic [WIDTH-1:0] f_read(input logic [ADDR_W-1:0] rn,
                                              input logic              byp);
    logic [WIDTH-1:0] q;
    if (rn == '0) begin
      q = '0;
    end else if (byp && w_commit && (rn == wrn)) begin
      q = w_wdi;
    end else begin
      q = r_regs[rn];
    end
    return q;
  endfunction

  assign qa       = f_read(rna, BYPASS != 0);
  assign qb       = f_read(rnb, BYPASS != 0);
  assign dbg_q    = f_read(dbg_rn, 1'b0);
  assign wdi      = w_wdi;
  assign wcommit  = w_commit;
  assign wb_count = r_wb_count;

endmodule
